// File: rtl/base_fifo_pkg.sv
// Shared helpers for the base FIFO family: pointer and occupancy widths
// derived from an arbitrary (not necessarily power-of-2) entry count.
package base_fifo_pkg;

    function automatic int base_clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Pointer width for a FIFO of the given depth.
    function automatic int base_aw(input int depth);
        return base_clog2_min1(depth);
    endfunction

    // Occupancy width: one extra bit so that "full" is representable.
    function automatic int base_cw(input int depth);
        return base_clog2_min1(depth) + 1;
    endfunction

endpackage

// File: rtl/base_afifo_oe_chk.sv
// Simulation-only property checker for base_afifo_oe.
module base_afifo_oe_chk #(
    parameter int depth = 2,
    parameter int dw    = 1,
    parameter int cw    = 2
) (
    input logic          clk,
    input logic          reset,
    input logic          o_v,
    input logic          o_en,
    input logic [0:dw-1] i_d,
    input logic [cw-1:0] o_cnt
);
    // occupancy bound, valid/occupancy agreement (no pop from empty), known data on push
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (o_cnt <= cw'(depth));
            assert (o_v == (o_cnt != '0));
            if (o_en) begin
                assert (!$isunknown(i_d));
            end
        end
    end

endmodule

// File: rtl/base_fifo_ptr.sv
// Entry pointer that advances on request and wraps from depth-1 back to 0.
module base_fifo_ptr
    import base_fifo_pkg::*;
#(
    parameter int depth = 2,
    parameter int aw    = base_aw(depth)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    output logic [aw-1:0] ptr
);
    localparam logic [aw-1:0] LAST = aw'(depth - 1);

    logic [aw-1:0] ptr_q;
    logic [aw-1:0] ptr_d;

    // next pointer with explicit wrap so non-power-of-2 depths work
    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            if (ptr_q == LAST) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + aw'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/base_afifo_oe.sv
// Parametrised-depth ready/valid FIFO exporting its push strobe and entry
// pointers; an optional delayed lane is captured one cycle after each accept.
module base_afifo_oe
    import base_fifo_pkg::*;
#(
    parameter int  width      = 1,
    parameter int  del_width  = 0,
    parameter int  depth      = 2,
    parameter int  pass_ready = 1,
    localparam int AW         = base_aw(depth),
    localparam int CW         = base_cw(depth)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_v,
    input  logic [0:width+del_width-1] i_d,
    output logic                       i_r,
    output logic                       o_v,
    output logic [0:width+del_width-1] o_d,
    input  logic                       o_r,
    output logic                       o_en,
    output logic [AW-1:0]              o_wa,
    output logic [AW-1:0]              o_ra,
    output logic [CW-1:0]              o_cnt
);
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);

    logic [AW-1:0] wptr_s;
    logic [AW-1:0] rptr_s;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          full_s;
    logic          nempty_s;
    logic          ready_s;
    logic          push_s;
    logic          pop_s;

    // handshake decode; with pass_ready a full FIFO still accepts when the head leaves
    always_comb begin
        full_s   = (cnt_q == DEPTH_C);
        nempty_s = (cnt_q != '0);
        if (pass_ready != 0) begin
            ready_s = ~full_s | o_r;
        end else begin
            ready_s = ~full_s;
        end
        push_s = i_v & ready_s;
        pop_s  = nempty_s & o_r;
    end

    // occupancy next state
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // occupancy register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    base_fifo_ptr #(.depth(depth), .aw(AW)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .adv   (push_s),
        .ptr   (wptr_s)
    );

    base_fifo_ptr #(.depth(depth), .aw(AW)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .adv   (pop_s),
        .ptr   (rptr_s)
    );

    generate
        if (width > 0) begin : g_lead
            logic [0:width-1] lead_mem [depth];

            // lead lane storage, written on the accept edge
            always_ff @(posedge clk) begin
                if (push_s) begin
                    lead_mem[wptr_s] <= i_d[0:width-1];
                end
            end

            assign o_d[0:width-1] = lead_mem[rptr_s];
        end

        if (del_width > 0) begin : g_del
            logic [0:del_width-1] del_mem [depth];
            logic [0:del_width-1] del_head_s;
            logic                 push_dly_q;
            logic                 push_dly_d;
            logic [AW-1:0]        wptr_dly_q;
            logic [AW-1:0]        wptr_dly_d;

            // remember which entry owes its delayed bits next cycle
            always_comb begin
                push_dly_d = push_s;
                if (push_s) begin
                    wptr_dly_d = wptr_s;
                end else begin
                    wptr_dly_d = wptr_dly_q;
                end
            end

            // delayed-write bookkeeping; reset drops any pending delayed write
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    push_dly_q <= 1'b0;
                    wptr_dly_q <= '0;
                end else begin
                    push_dly_q <= push_dly_d;
                    wptr_dly_q <= wptr_dly_d;
                end
            end

            // delayed lane storage, written one edge after the accept
            always_ff @(posedge clk) begin
                if (push_dly_q) begin
                    del_mem[wptr_dly_q] <= i_d[width +: del_width];
                end
            end

            // a head accepted last cycle has not had its delayed bits stored yet
            always_comb begin
                if (push_dly_q && (wptr_dly_q == rptr_s)) begin
                    del_head_s = i_d[width +: del_width];
                end else begin
                    del_head_s = del_mem[rptr_s];
                end
            end

            assign o_d[width +: del_width] = del_head_s;
        end
    endgenerate

    assign i_r   = ready_s;
    assign o_v   = nempty_s;
    assign o_en  = push_s;
    assign o_wa  = wptr_s;
    assign o_ra  = rptr_s;
    assign o_cnt = cnt_q;

endmodule

// File: tb/tb_base_afifo_oe.sv
// Randomised scoreboard bench for base_afifo_oe: a queue-based reference model
// per instance predicts handshakes, entry indices, occupancy and popped data.
module tb_base_afifo_oe;

    logic       clk = 1'b0;
    logic       reset;
    logic       v0, r0, v1, r1;
    logic [0:7] d0, d1;
    logic       ir0, ov0, en0, ir1, ov1, en1;
    logic [0:7] od0, od1;
    logic [1:0] wa0, ra0, wa1, ra1;
    logic [2:0] cnt0, cnt1;

    int checks = 0;
    int fails  = 0;

    // reference model state, one slot per instance
    logic [7:0] mq [2][$];
    bit         pend [2];
    int         pushes [2];
    int         pops [2];
    int         depth_m [2] = '{3, 4};
    bit         pr_m [2]    = '{1'b1, 1'b0};
    logic [7:0] lead_m [2]  = '{8'hF0, 8'hFF};

    always #5 clk = ~clk;

    // u0: split lanes, odd depth, pass-through ready
    base_afifo_oe #(.width(4), .del_width(4), .depth(3), .pass_ready(1)) u0 (
        .clk(clk), .reset(reset), .i_v(v0), .i_d(d0), .i_r(ir0), .o_v(ov0), .o_d(od0),
        .o_r(r0), .o_en(en0), .o_wa(wa0), .o_ra(ra0), .o_cnt(cnt0)
    );

    // u1: single lane, depth 4, registered ready
    base_afifo_oe #(.width(8), .del_width(0), .depth(4), .pass_ready(0)) u1 (
        .clk(clk), .reset(reset), .i_v(v1), .i_d(d1), .i_r(ir1), .o_v(ov1), .o_d(od1),
        .o_r(r1), .o_en(en1), .o_wa(wa1), .o_ra(ra1), .o_cnt(cnt1)
    );

    base_afifo_oe_chk #(.depth(3), .dw(8), .cw(3)) c0 (
        .clk(clk), .reset(reset), .o_v(ov0), .o_en(en0), .i_d(d0), .o_cnt(cnt0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model(input int k, input logic rst, input logic iv, input logic [7:0] id,
                         input logic orr, input logic ir, input logic ov, input logic en,
                         input logic [7:0] od, input logic [1:0] wa, input logic [1:0] ra,
                         input logic [2:0] cnt);
        int         sz;
        logic       rdy;
        logic [7:0] head;
        if (rst) begin
            mq[k].delete();
            pend[k]   = 1'b0;
            pushes[k] = 0;
            pops[k]   = 0;
            chk($sformatf("u%0d.rst_o_v", k), 32'(ov), 32'd0);
            chk($sformatf("u%0d.rst_o_cnt", k), 32'(cnt), 32'd0);
            chk($sformatf("u%0d.rst_o_wa", k), 32'(wa), 32'd0);
            chk($sformatf("u%0d.rst_o_ra", k), 32'(ra), 32'd0);
            chk($sformatf("u%0d.rst_i_r", k), 32'(ir), 32'd1);
            return;
        end
        if (pend[k]) begin
            mq[k][mq[k].size()-1] = (mq[k][mq[k].size()-1] & lead_m[k]) | (id & ~lead_m[k]);
        end
        sz  = mq[k].size();
        rdy = (sz != depth_m[k]) || (pr_m[k] && orr);
        chk($sformatf("u%0d.i_r", k), 32'(ir), 32'(rdy));
        chk($sformatf("u%0d.o_v", k), 32'(ov), 32'(sz != 0));
        chk($sformatf("u%0d.o_cnt", k), 32'(cnt), 32'(sz));
        if (rdy) chk($sformatf("u%0d.o_wa", k), 32'(wa), 32'(pushes[k] % depth_m[k]));
        if (sz != 0) chk($sformatf("u%0d.o_ra", k), 32'(ra), 32'(pops[k] % depth_m[k]));
        if (sz != 0 && orr) begin
            head = mq[k].pop_front();
            chk($sformatf("u%0d.o_d", k), 32'(od), 32'(head));
            pops[k]++;
        end
        pend[k] = 1'b0;
        chk($sformatf("u%0d.o_en", k), 32'(en), 32'(iv && rdy));
        if (iv && rdy) begin
            mq[k].push_back(id & lead_m[k]);
            pushes[k]++;
            pend[k] = 1'b1;
        end
    endtask

    // monitor: inputs are stable mid-cycle, so model and compare on the falling edge
    always @(negedge clk) begin
        model(0, reset, v0, d0, r0, ir0, ov0, en0, od0, wa0, ra0, cnt0);
        model(1, reset, v1, d1, r1, ir1, ov1, en1, od1, wa1, ra1, cnt1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        v0 = 1'b0; r0 = 1'b0; d0 = 8'h00;
        v1 = 1'b0; r1 = 1'b0; d1 = 8'h00;
        step(2);
        reset = 1'b0;

        // u1: fill four deep with o_r low, fifth offer must be held off
        for (int i = 0; i < 5; i++) begin
            v1 = 1'b1;
            d1 = 8'(8'h11 * (i + 1));
            step(1);
        end
        d1 = 8'h66; r1 = 1'b1;
        step(1);
        v1 = 1'b0;
        step(5);

        // u0: delayed lane forwarded into a pop on the cycle after the accept
        v0 = 1'b1; d0 = 8'hA0; r0 = 1'b1;
        step(1);
        v0 = 1'b0; d0 = 8'hF5;
        step(1);
        d0 = 8'h00;
        step(1);

        // u0: stream through the depth-3 wrap with o_r toggling
        for (int i = 0; i < 14; i++) begin
            v0 = 1'b1;
            d0 = 8'($urandom);
            r0 = (i % 2 == 0);
            step(1);
        end
        v0 = 1'b0; r0 = 1'b1;
        step(4);

        // u0: fill, then push and pop together while full
        r0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v0 = 1'b1;
            d0 = 8'($urandom);
            step(1);
        end
        r0 = 1'b1; d0 = 8'h9C;
        step(1);
        v0 = 1'b0; d0 = 8'h00;
        step(4);

        // random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            v0 = 1'($urandom_range(0, 1));
            d0 = 8'($urandom);
            r0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            d1 = 8'($urandom);
            r1 = 1'($urandom_range(0, 1));
            step(1);
        end
        v0 = 1'b0; v1 = 1'b0; r0 = 1'b1; r1 = 1'b1;
        step(5);

        // reset mid-operation with two entries queued and a delayed write pending
        r0 = 1'b0; v0 = 1'b1; d0 = 8'h12;
        step(1);
        d0 = 8'h34;
        step(1);
        v0 = 1'b0; d0 = 8'hEE;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_o_v", 32'(ov0), 32'd0);
        chk("async_rst_o_cnt", 32'(cnt0), 32'd0);
        chk("async_rst_o_wa", 32'(wa0), 32'd0);
        chk("async_rst_o_ra", 32'(ra0), 32'd0);
        step(1);
        reset = 1'b0;
        v0 = 1'b1; d0 = 8'hC0;
        step(1);
        v0 = 1'b0; d0 = 8'h03;
        step(1);
        r0 = 1'b1; d0 = 8'h00;
        step(3);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
